// File: rtl/atomic_link_unit.sv
// atomic_link_unit: per-core LL/SC reservation tracker in front of a shared
// data-memory port. One access is committed per cycle, chosen round-robin;
// each core keeps a single word-granular link that SCs test and that
// conflicting writes (or an optional timeout) invalidate.
module atomic_link_unit #(
    parameter int CPUS         = 2,
    parameter int AW           = 32,
    parameter int LINK_TIMEOUT = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CPUS-1:0]     req_ren,
    input  logic [CPUS-1:0]     req_wen,
    input  logic [CPUS-1:0]     req_atomic,
    input  logic [CPUS*AW-1:0]  req_addr,
    output logic [CPUS-1:0]     grant,
    output logic                sc_ok,
    output logic                mem_ren,
    output logic                mem_wen,
    output logic [AW-1:0]       mem_addr,
    output logic [CPUS-1:0]     link_valid
);

    // A single core still needs a 1-bit pointer so the declarations stay legal.
    localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

    logic [PW-1:0]   ptr;
    logic [CPUS-1:0] lv;
    logic [AW-3:0]   la [CPUS];
    logic [CPUS-1:0] expire;

    logic [CPUS-1:0] req;
    logic            found;
    logic [PW-1:0]   gidx;
    int              idx;

    logic [AW-1:0]   gaddr;
    logic [AW-3:0]   gword;
    logic            g_ren;
    logic            g_wen;
    logic            g_atom;
    logic            own_match;
    logic [CPUS-1:0] match;
    logic [CPUS-1:0] ll_set;
    logic            clear_matching;

    assign req        = req_ren | req_wen;
    assign link_valid = lv;

    // Round-robin arbiter: first requester at or after ptr, wrapping at CPUS.
    always_comb begin
        grant = '0;
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        for (int i = 0; i < CPUS; i++) begin
            idx = (int'(ptr) + i) % CPUS;
            if (!found && req[idx]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end
        if (found) grant[gidx] = 1'b1;
    end

    // Decode the granted access and decide the SC outcome against the links.
    always_comb begin
        gaddr     = '0;
        own_match = 1'b0;
        for (int c = 0; c < CPUS; c++) begin
            if (grant[c]) begin
                gaddr = req_addr[c*AW +: AW];
            end
        end
        gword  = gaddr[AW-1:2];
        g_ren  = |(grant & req_ren);
        g_wen  = |(grant & req_wen);
        g_atom = |(grant & req_atomic);
        for (int c = 0; c < CPUS; c++) begin
            match[c] = lv[c] && (la[c] == gword);
            if (grant[c] && match[c]) own_match = 1'b1;
        end
        sc_ok          = g_wen && g_atom && own_match;
        mem_ren        = g_ren;
        mem_wen        = g_wen && (!g_atom || own_match);
        mem_addr       = gaddr;
        // Any write that actually reaches memory kills every link on that word.
        clear_matching = mem_wen;
        ll_set         = grant & req_ren & req_atomic;
    end

    // Advance the arbiter pointer past the core just served.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gidx == PW'(CPUS - 1)) ? '0 : gidx + 1'b1;
        end
    end

    // Link registers; LL is applied last so it wins over a same-cycle expiry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lv <= '0;
            for (int c = 0; c < CPUS; c++) la[c] <= '0;
        end else begin
            for (int c = 0; c < CPUS; c++) begin
                if (expire[c]) lv[c] <= 1'b0;
                if (grant[c] && g_wen && g_atom) lv[c] <= 1'b0;
                if (clear_matching && match[c]) lv[c] <= 1'b0;
                if (ll_set[c]) begin
                    lv[c] <= 1'b1;
                    la[c] <= gword;
                end
            end
        end
    end

    if (LINK_TIMEOUT > 0) begin : g_timeout
        localparam int CW = (LINK_TIMEOUT > 1) ? $clog2(LINK_TIMEOUT) : 1;
        logic [CW-1:0] cnt [CPUS];

        // Age of each valid link; restarts on every LL.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                for (int c = 0; c < CPUS; c++) cnt[c] <= '0;
            end else begin
                for (int c = 0; c < CPUS; c++) begin
                    if (ll_set[c]) begin
                        cnt[c] <= '0;
                    end else if (lv[c]) begin
                        cnt[c] <= (cnt[c] == CW'(LINK_TIMEOUT - 1)) ? '0 : cnt[c] + 1'b1;
                    end
                end
            end
        end

        // A link expires in the last cycle of its LINK_TIMEOUT-cycle lifetime.
        always_comb begin
            for (int c = 0; c < CPUS; c++) begin
                expire[c] = lv[c] && (cnt[c] == CW'(LINK_TIMEOUT - 1));
            end
        end
    end else begin : g_no_timeout
        assign expire = '0;
    end

endmodule

// File: doc/atomic_link_unit.md
# atomic_link_unit

Parametrised load-linked / store-conditional reservation tracker for the multicore datapath. It sits between the per-core data-memory request ports, where each core's control unit supplies `dREN`/`dWEN`/`datomic`, and the shared data-memory port. It serialises one data access per cycle with a round-robin arbiter and keeps a word-granular link register per core. It decides SC success, suppresses failed SC writes, and optionally expires links after a timeout.

## Interface
Parameters:
- `CPUS`, 2: number of cores/request channels (≥1)
- `AW`, 32: byte-address width; links compare bits `[AW-1:2]`
- `LINK_TIMEOUT`, 0: cycles a link stays valid before auto-expiry; 0 disables expiry

Ports:
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `req_ren`  in  CPUS  per-core read request (`dREN`)
- `req_wen`  in  CPUS  per-core write request (`dWEN`); `req_ren` and `req_wen` are never both high for the same core
- `req_atomic`  in  CPUS  per-core `datomic`: read means LL, write means SC
- `req_addr`  in  CPUS*AW  per-core byte address; core c occupies `[c*AW +: AW]`
- `grant`  out  CPUS  one-hot; the core whose access commits this cycle
- `sc_ok`  out  1  granted access is an SC that succeeds
- `mem_ren`  out  1  read forwarded to memory
- `mem_wen`  out  1  write forwarded to memory (plain write or successful SC)
- `mem_addr`  out  AW  granted core's address; 0 when no grant
- `link_valid`  out  CPUS  per-core link-valid flags (registered)

## Operation
- Request of core c is `req_ren[c] | req_wen[c]`. The core holds it stable until `grant[c]`.
- Arbiter: register `ptr` (width clog2(CPUS), reset 0). Grant goes to the first requesting core scanning `ptr, ptr+1, …` with wrap at CPUS. After a grant to g, `ptr <= (g+1) mod CPUS`. With no request, `ptr` is unchanged.
- Per-core state: `lv[c]`, `la[c]` (AW-2 bits), and `cnt[c]` (present only if `LINK_TIMEOUT>0`).
- Granted LL by core c: at the next edge `lv[c]<=1`, `la[c]<=addr[AW-1:2]`, `cnt[c]<=0`. `mem_ren=1`.
- Granted plain read: `mem_ren=1`; link state unchanged.
- Granted SC by core c: `sc_ok = lv[c] && la[c]==addr[AW-1:2]`. `mem_wen=sc_ok`. At the edge `lv[c]<=0` regardless of outcome.
  - If `sc_ok`, every core k with `lv[k] && la[k]==addr[AW-1:2]` is also cleared.
- Granted plain write: `mem_wen=1`. Every link matching `addr[AW-1:2]`, including the writer's own, is cleared.
- Timeout (`LINK_TIMEOUT>0`): while `lv[c]`, `cnt[c]` increments each cycle. When `cnt[c]==LINK_TIMEOUT-1`, `lv[c]<=0`, so the link is valid for exactly `LINK_TIMEOUT` cycles.
- Simultaneous events:
  - LL by c in the same cycle as c's expiry: LL wins (set, counter restarts).
  - LL by c re-linking while a link is valid: overwrite address and restart counter.
- `sc_ok`, `mem_ren`, `mem_wen` and `mem_addr` are 0 whenever `grant==0`.

## Timing
- `grant`, `sc_ok`, `mem_*`: combinational from current inputs and state, valid in the request cycle. Zero-cycle decision latency.
- Link and `ptr` updates take effect at the next rising edge. An SC in the cycle after the matching LL grant sees `lv=1`.
- An SC issued in the same cycle as a conflicting write from another core is impossible, because only one access is granted per cycle. Ordering is purely grant order.
- Reset values (immediate on `RST` assertion, independent of `CLK`):
  - `lv=0`, `la=0`, `cnt=0`, `ptr=0`
  - `link_valid=0`
  - combinational outputs follow these states, so they are 0 absent requests
- Reset mid-operation discards all links. The first edge after deassertion behaves as post-reset.

## Test plan
- Reset; core0 LL 0x100; next cycle core0 SC 0x100 → `sc_ok=1`, `mem_wen=1`, `mem_addr=0x100`; `link_valid[0]=0` after the edge.
- Core0 LL 0x100; core1 plain write 0x100 → `link_valid[0]` drops. Core0 SC 0x100 → `sc_ok=0`, `mem_wen=0`.
- Core0 LL 0x100; core1 write 0x104 → link kept. Core1 write 0x102 (same word) → link cleared.
- CPUS=2, both cores request continuously from reset → grants 0,1,0,1…; only core1 requesting while `ptr=0` → core1 granted immediately.
- `LINK_TIMEOUT=4`: LL at cycle 0 → `link_valid[0]` high cycles 1–4, low from cycle 5. SC at cycle 5 → `sc_ok=0`. Re-LL at cycle 3 → valid through cycle 7.
- Two cores LL 0x200; core1 SC 0x200 succeeds → both links cleared; core0 SC 0x200 → `sc_ok=0`. Assert `RST` asynchronously with links valid → `link_valid=0` before the next edge.
